// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder: resolution codes,
// the {A,B} state type and the transition classifier.
package quad_pkg;

  localparam logic [1:0] RES_X1      = 2'd0;
  localparam logic [1:0] RES_X2      = 2'd1;
  localparam logic [1:0] RES_X4      = 2'd2;
  localparam logic [1:0] RES_ILLEGAL = 2'd3;

  // Filter counter width, enough for FILTER_CYCLES up to 15.
  localparam int CNT_W = 4;

  typedef logic [1:0] quad_state_t;  // {A, B}

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DOWN,
    TR_ILLEGAL
  } quad_trans_t;

  // Forward (A leads B) successor: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_state_t next_up(quad_state_t s);
    quad_state_t n;
    case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic quad_trans_t classify(quad_state_t prev, quad_state_t cur);
    quad_trans_t t;
    if (prev == cur)                t = TR_NONE;
    else if ((prev ^ cur) == 2'b11) t = TR_ILLEGAL;
    else if (next_up(prev) == cur)  t = TR_UP;
    else                            t = TR_DOWN;
    return t;
  endfunction

  // Whether a legal single-bit transition is counted at the given resolution.
  function automatic logic counted(logic [1:0] res, quad_state_t prev, quad_state_t cur);
    logic c;
    case (res)
      RES_X4:  c = 1'b1;
      RES_X2:  c = (prev[1] != cur[1]);
      RES_X1:  c = ((prev == 2'b00) && (cur == 2'b10)) || ((prev == 2'b10) && (cur == 2'b00));
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: 2-flop synchronizer followed by a persistence filter.
// A change is accepted only after FILTER_CYCLES consecutive differing samples.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  output logic sync2,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // load primes the filter straight from the synchronizer after reset
      if (load) begin
        filt <= sync2;
        cnt  <= '0;
      end else if (sync2 == filt) begin
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: filtered channels feed a transition classifier that
// emits one-cycle step pulses with direction and a sticky illegal-move flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int         FILTER_CYCLES = 4,
  parameter logic [1:0] RES           = RES_X4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic quad_a,
  input  logic quad_b,
  input  logic enable,
  input  logic clear_err,
  output logic step,
  output logic dir,
  output logic error
);

  if (RES == RES_ILLEGAL) begin : g_bad_res
    $error("quad_step_decoder: RES=3 is not a valid resolution");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
    $error("quad_step_decoder: FILTER_CYCLES must be 1..15");
  end

  logic [1:0]  raw;
  quad_state_t sync2;
  quad_state_t filt;
  quad_state_t s_prev;
  logic [1:0]  prime_cnt;
  logic        primed;
  logic        prime_load;
  quad_trans_t tr;
  logic        hit;

  assign raw = {quad_a, quad_b};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .load  (prime_load),
      .sync2 (sync2[i]),
      .filt  (filt[i])
    );
  end

  // Third edge after release: sync2 now carries the real input level.
  assign prime_load = !primed && (prime_cnt == 2'd2);

  assign tr  = classify(s_prev, filt);
  assign hit = ((tr == TR_UP) || (tr == TR_DOWN)) && counted(RES, s_prev, filt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= 2'd0;
      primed    <= 1'b0;
      s_prev    <= 2'b00;
      step      <= 1'b0;
      dir       <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
      if (prime_load) primed <= 1'b1;
      // s_prev follows the primed value so the priming load never looks like a move
      s_prev <= prime_load ? sync2 : filt;
      step   <= primed && enable && hit;
      if (primed && enable && hit) dir <= (tr == TR_UP);
      error  <= (primed && (tr == TR_ILLEGAL)) || (error && !clear_err);
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: three decoders (X4, X2, X1) share one randomized/directed
// A/B stream; a run-length reference model predicts steps, dir and error.
module tb_quad_step_decoder;

  localparam int FC = 4;
  localparam int NDUT = 3;  // index 0 = X4, 1 = X2, 2 = X1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic quad_a = 1'b0, quad_b = 1'b0, enable = 1'b1, clear_err = 1'b0;
  logic [NDUT-1:0] step_v, dir_v, err_v;

  always #5 clk = ~clk;

  quad_step_decoder #(.FILTER_CYCLES(FC), .RES(2'd2)) dut_x4 (
    .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .enable(enable),
    .clear_err(clear_err), .step(step_v[0]), .dir(dir_v[0]), .error(err_v[0]));
  quad_step_decoder #(.FILTER_CYCLES(FC), .RES(2'd1)) dut_x2 (
    .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .enable(enable),
    .clear_err(clear_err), .step(step_v[1]), .dir(dir_v[1]), .error(err_v[1]));
  quad_step_decoder #(.FILTER_CYCLES(FC), .RES(2'd0)) dut_x1 (
    .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .enable(enable),
    .clear_err(clear_err), .step(step_v[2]), .dir(dir_v[2]), .error(err_v[2]));

  typedef struct { int e; bit d; } exp_t;
  exp_t expq [NDUT][$];

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  bit ra [0:16383];
  bit rb [0:16383];
  int n = 0;
  bit primed_m = 0;
  bit [1:0] fs = 0, fs_prev = 0;
  int last_a = 0, last_b = 0;
  bit err_m = 0;
  bit dir_m [NDUT];

  // Position around the forward cycle 00,10,11,01.
  function automatic int pos(bit [1:0] s);
    case (s)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit counts(int r, bit [1:0] o, bit [1:0] c);
    if (r == 0) return 1;
    if (r == 1) return o[1] != c[1];
    return (pos(o) + pos(c)) == 1;  // only the 00 <-> 10 boundary
  endfunction

  // A channel flips when its raw level disagreed with the filtered value for
  // the last FC synchronized samples, all after the last accepted change.
  function automatic bit flips(bit ch_a, bit cur, int last);
    if (n - FC < last) return 0;
    for (int e = n - FC + 1; e <= n; e++)
      if ((ch_a ? ra[e-2] : rb[e-2]) == cur) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; primed_m = 0; fs = 0; fs_prev = 0; err_m = 0;
      for (int r = 0; r < NDUT; r++) begin dir_m[r] = 0; expq[r].delete(); end
    end else begin
      bit set_err;
      bit [1:0] nf;
      int d;
      n++;
      ra[n] = quad_a; rb[n] = quad_b;
      set_err = 0;
      if (primed_m && fs != fs_prev) begin
        d = (pos(fs) - pos(fs_prev) + 4) % 4;
        if (d == 2) set_err = 1;
        else if (enable)
          for (int r = 0; r < NDUT; r++)
            if (counts(r, fs_prev, fs)) begin
              expq[r].push_back('{e: n, d: (d == 1)});
              dir_m[r] = (d == 1);
            end
      end
      err_m = set_err | (err_m & ~clear_err);
      if (n == 3) begin
        fs = {ra[1], rb[1]}; fs_prev = fs; primed_m = 1; last_a = 3; last_b = 3;
      end else begin
        fs_prev = fs;
        nf = fs;
        if (n > 3) begin
          if (flips(1, fs[1], last_a)) begin nf[1] = ~fs[1]; last_a = n; end
          if (flips(0, fs[0], last_b)) begin nf[0] = ~fs[0]; last_b = n; end
        end
        fs = nf;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < NDUT; r++) begin
      total++;
      if (step_v[r]) begin
        if (expq[r].size() == 0 || expq[r][0].e != n) begin
          bad++;
          $display("FAIL step_unexpected dut%0d edge=%0d got step=1 want step=0", r, n);
        end else begin
          exp_t x;
          x = expq[r].pop_front();
          if (dir_v[r] !== x.d) begin
            bad++;
            $display("FAIL step_dir dut%0d edge=%0d got dir=%0b want dir=%0b", r, n, dir_v[r], x.d);
          end
        end
      end else if (expq[r].size() > 0 && expq[r][0].e <= n) begin
        exp_t x;
        x = expq[r].pop_front();
        bad++;
        $display("FAIL step_missing dut%0d edge=%0d got step=0 want step=1 dir=%0b", r, x.e, x.d);
      end
      total++;
      if (dir_v[r] !== dir_m[r]) begin
        bad++;
        $display("FAIL dir_hold dut%0d edge=%0d got=%0b want=%0b", r, n, dir_v[r], dir_m[r]);
      end
      total++;
      if (err_v[r] !== err_m) begin
        bad++;
        $display("FAIL error dut%0d edge=%0d got=%0b want=%0b", r, n, err_v[r], err_m);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit a, bit b, int cyc);
    quad_a = a; quad_b = b;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    // reset with both channels high: primes to 11, no step or error
    quad_a = 1; quad_b = 1;
    do_reset();
    drive(1, 1, 20);
    drive(0, 1, 10);  // 11 -> 01 forward, proves primed state was 11
    drive(0, 0, 10);
    // forward cycle
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10);
    // two reverse cycles
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
    end
    // 3-cycle glitch rejected, 4-cycle pulse accepted both ways
    drive(1, 0, 3); drive(0, 0, 12);
    drive(1, 0, 4); drive(0, 0, 12);
    // illegal jump, then clear
    drive(1, 1, 12);
    clear_err = 1; @(negedge clk); clear_err = 0;
    drive(1, 1, 6);
    // illegal 11 -> 00 with clear_err landing on the same edge as the set
    quad_a = 0; quad_b = 0;
    repeat (6) @(negedge clk);
    clear_err = 1; @(negedge clk); clear_err = 0;
    drive(0, 0, 8);
    clear_err = 1; @(negedge clk); clear_err = 0;
    drive(0, 0, 6);
    // gated steps while tracking continues
    enable = 0;
    drive(1, 0, 10); drive(1, 1, 10);
    enable = 1;
    drive(0, 1, 12);
    // randomized phase with one reset mid-stream
    for (int it = 0; it < 200; it++) begin
      int mode;
      bit na, nb;
      if (it == 100) begin
        do_reset();
        drive(quad_a, quad_b, 8);
      end
      mode = $urandom_range(0, 9);
      na = quad_a; nb = quad_b;
      if (mode < 4) na = ~na;
      else if (mode < 8) nb = ~nb;
      else if (mode == 8) begin na = ~na; nb = ~nb; end
      enable = ($urandom_range(0, 7) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      quad_a = na; quad_b = nb;
      @(negedge clk);
      clear_err = 0;
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    enable = 1;
    drive(quad_a, quad_b, 20);
    for (int r = 0; r < NDUT; r++) begin
      total++;
      if (expq[r].size() != 0) begin
        bad++;
        $display("FAIL drain dut%0d got %0d pending want 0", r, expq[r].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Decodes a two-channel quadrature input (A/B) into single-cycle step pulses plus a direction bit. The outputs drive the enable/up_down inputs of the up/down counter, so a counter can track a rotary encoder's position. Each raw input passes through a 2-flop synchronizer and a glitch filter. Illegal double transitions are flagged in a sticky error bit.

## Interface
- FILTER_CYCLES, default 4: consecutive cycles a synchronized input must differ from its filtered value before the change is accepted; legal range 1..15.
- RES, default 2'd2 (X4): decode resolution; 2'd0 = X1, 2'd1 = X2, 2'd2 = X4. 2'd3 is illegal and must fail elaboration.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- quad_a  in  1  raw encoder channel A, asynchronous to clk.
- quad_b  in  1  raw encoder channel B, asynchronous to clk.
- enable  in  1  1 = steps may be emitted; 0 = state tracking continues, step is held 0.
- clear_err  in  1  synchronous clear of error.
- step  out  1  one-cycle pulse per counted transition; feeds counter enable.
- dir  out  1  1 = up (A leads B), 0 = down; updated with step, held otherwise.
- error  out  1  sticky illegal-transition flag.

## Operation
- Reset values: step=0, dir=0, error=0, sync flops=0, filter counters=0, filtered A/B=0, primed=0.
- Synchronizer: 2 flops per channel. sync2 is the synchronized value.
- Filter, per channel:
  - When sync2 ≠ filtered, the counter increments.
  - When sync2 = filtered, the counter clears to 0.
  - When sync2 ≠ filtered and the counter = FILTER_CYCLES-1, filtered takes sync2 and the counter clears.
- Priming:
  - At the 3rd clock edge after rst_n release, filtered A/B load sync2 directly and primed is set.
  - The priming load never produces step or error.
- State S = {A_f, B_f}.
  - Up sequence: 00→10→11→01→00.
  - Down sequence: the reverse.
- Transition classification, evaluated on each edge where primed=1 and S changes:
  - Legal transition (one bit changes):
    - Counted when RES=X4: all legal transitions.
    - Counted when RES=X2: transitions where A changes.
    - Counted when RES=X1: only 00↔10.
    - A counted transition gives step=1 and dir=1 if up, 0 if down, provided enable=1.
    - A non-counted transition, or any transition with enable=0: step=0, dir holds.
  - Illegal transition (both bits change in the same cycle, 00↔11 or 10↔01):
    - step=0, dir holds, error set.
    - S still adopts the new value.
- error stays set until clear_err=1. If a set and clear_err occur in the same cycle, the set wins and error stays 1.
- Reset asserted mid-operation clears everything immediately. Priming repeats after release.

## Timing
- Input change stable before edge k:
  - sync1 at k, sync2 at k+1.
  - filtered updates at k+FILTER_CYCLES+1.
  - step/dir/error registered at k+FILTER_CYCLES+2.
  - With the default, step is high for the cycle after edge k+6.
- step is exactly one cycle wide. Back-to-back steps on consecutive cycles are possible only when the channels change on alternating cycles.
- A pulse shorter than FILTER_CYCLES synchronized cycles is fully rejected.
- A and B filters expiring on the same edge counts as an illegal transition.
- Maximum legal step rate: one transition per FILTER_CYCLES+1 cycles per channel.

## Structure
- Package quad_pkg:
  - Resolution constants RES_X1/RES_X2/RES_X4.
  - 2-bit typedef quad_state_t.
  - Function classifying (old, new) into {NONE, UP, DOWN, ILLEGAL}.
- Sub-module quad_input_filter: synchronizer, glitch-filter counter and filtered output, parameterized by FILTER_CYCLES. Instantiated once per channel.
- Top level holds primed, the state/transition decode and the output registers.

## Test plan
- Reset with quad_a=quad_b=1 held: after release, filtered state = 11, no step, error=0 throughout.
- X4, FILTER_CYCLES=4, enable=1, drive 00→10→11→01→00 with each state held 10 cycles: 4 step pulses, dir=1, each step 6 cycles after the input edge.
- X1, drive 2 full down cycles: exactly 2 steps with dir=0. X2 on the same stimulus: 4 steps.
- Glitch on quad_a lasting 3 cycles with FILTER_CYCLES=4: no step, state unchanged. A 4-cycle pulse gives 2 steps (up then down).
- Simultaneous 00→11: error=1, no step. clear_err pulse gives error=0. clear_err coinciding with an illegal 11→00: error stays 1.
- enable=0 across two forward transitions, then enable=1 and one more: exactly 1 step with dir=1, no error, proving tracking continued while step was gated.
